// File: rtl/dac_playback_scheduler.sv
// Ping-pong playback scheduler: one bank fills from the producer while the other
// drains one frame per sample tick; swaps banks, plays silence and counts underruns.
module dac_playback_scheduler #(
   parameter int unsigned DEPTH = 128,
   parameter int unsigned DW    = 48
) (
   input  logic          cmn_clk,
   input  logic          cmn_rst_n,
   input  logic          enable,
   input  logic          s_tvalid,
   output logic          s_tready,
   input  logic [DW-1:0] s_tdata,
   input  logic          frame_req,
   output logic          m_tvalid,
   output logic [DW-1:0] m_tdata,
   output logic          underrun,
   output logic [15:0]   underrun_cnt,
   output logic          fill_sel,
   output logic          playing
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = AW + 1;
   localparam logic [CW-1:0] FULL = CW'(DEPTH);

   typedef enum logic [1:0] {IDLE, PRIME, RUN, STARVE} state_t;

   state_t        state;
   state_t        state_nxt;
   logic [DW-1:0] mem [2*DEPTH];
   logic [CW-1:0] fill_cnt;
   logic [CW-1:0] play_cnt;
   logic [CW-1:0] fill_nxt;
   logic [CW-1:0] play_nxt;
   logic [AW-1:0] rd_idx;
   logic [AW-1:0] wr_idx;
   logic          wr_fire;
   logic          rd_fire;
   logic          starve_req;
   logic          swap;
   logic          flush;

   // State register
   always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
      if (!cmn_rst_n) state <= IDLE;
      else            state <= state_nxt;
   end

   // Next state; swap decisions look at the post-edge fill/play counts
   always_comb begin
      state_nxt = state;
      swap      = 1'b0;
      flush     = 1'b0;
      if (!enable) begin
         state_nxt = IDLE;
         flush     = 1'b1;
      end else begin
         case (state)
            IDLE:          state_nxt = PRIME;
            PRIME, STARVE: begin
               if (fill_nxt == FULL) begin
                  swap      = 1'b1;
                  state_nxt = RUN;
               end
            end
            RUN: begin
               if (play_nxt == '0) begin
                  if (fill_nxt == FULL) swap = 1'b1;
                  else                  state_nxt = STARVE;
               end
            end
            default:       state_nxt = IDLE;
         endcase
      end
   end

   // Decodes of the registered state
   always_comb begin
      s_tready   = (state != IDLE) && (fill_cnt != FULL);
      playing    = (state == RUN);
      rd_fire    = (state == RUN) && frame_req;
      starve_req = (state == STARVE) && frame_req;
      wr_fire    = s_tvalid && s_tready;
      wr_idx     = fill_cnt[AW-1:0];
      fill_nxt   = fill_cnt + CW'(wr_fire);
      play_nxt   = play_cnt - CW'(rd_fire);
   end

   // Bank bookkeeping
   always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
      if (!cmn_rst_n) begin
         fill_cnt <= '0;
         play_cnt <= '0;
         rd_idx   <= '0;
         fill_sel <= 1'b0;
      end else if (flush) begin
         fill_cnt <= '0;
         play_cnt <= '0;
         rd_idx   <= '0;
         fill_sel <= 1'b0;
      end else if (swap) begin
         fill_cnt <= '0;
         play_cnt <= FULL;
         rd_idx   <= '0;
         fill_sel <= ~fill_sel;
      end else begin
         fill_cnt <= fill_nxt;
         play_cnt <= play_nxt;
         if (rd_fire) rd_idx <= rd_idx + AW'(1);
      end
   end

   // Frame storage is deliberately left unreset
   always_ff @(posedge cmn_clk) begin
      if (wr_fire) mem[{fill_sel, wr_idx}] <= s_tdata;
   end

   // Registered response to each sample tick; silence outside RUN
   always_ff @(posedge cmn_clk or negedge cmn_rst_n) begin
      if (!cmn_rst_n) begin
         m_tvalid     <= 1'b0;
         m_tdata      <= '0;
         underrun     <= 1'b0;
         underrun_cnt <= '0;
      end else begin
         m_tvalid <= frame_req;
         underrun <= starve_req;
         if (frame_req) m_tdata <= rd_fire ? mem[{~fill_sel, rd_idx}] : '0;
         if (starve_req && (underrun_cnt != 16'hFFFF)) underrun_cnt <= underrun_cnt + 16'd1;
      end
   end

endmodule

// File: tb/tb_dac_playback_scheduler.sv
// Directed bench for dac_playback_scheduler (DEPTH=4) with a response scoreboard.
module tb_dac_playback_scheduler;

   localparam int unsigned DEPTH = 4;
   localparam int unsigned DW    = 48;

   typedef struct packed {
      logic          u;
      logic [DW-1:0] d;
   } exp_t;

   logic          cmn_clk;
   logic          cmn_rst_n;
   logic          enable;
   logic          s_tvalid;
   logic          s_tready;
   logic [DW-1:0] s_tdata;
   logic          frame_req;
   logic          m_tvalid;
   logic [DW-1:0] m_tdata;
   logic          underrun;
   logic [15:0]   underrun_cnt;
   logic          fill_sel;
   logic          playing;

   int   checks = 0;
   int   errors = 0;
   exp_t exp_q[$];

   dac_playback_scheduler #(.DEPTH(DEPTH), .DW(DW)) dut (
      .cmn_clk      (cmn_clk),
      .cmn_rst_n    (cmn_rst_n),
      .enable       (enable),
      .s_tvalid     (s_tvalid),
      .s_tready     (s_tready),
      .s_tdata      (s_tdata),
      .frame_req    (frame_req),
      .m_tvalid     (m_tvalid),
      .m_tdata      (m_tdata),
      .underrun     (underrun),
      .underrun_cnt (underrun_cnt),
      .fill_sel     (fill_sel),
      .playing      (playing)
   );

   initial begin
      cmn_clk = 1'b0;
      forever #5 cmn_clk = ~cmn_clk;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic cycle();
      @(posedge cmn_clk);
      #1;
   endtask

   task automatic push_exp(input logic [DW-1:0] d, input logic u);
      exp_t e;
      e.u = u;
      e.d = d;
      exp_q.push_back(e);
   endtask

   task automatic wr(input logic [DW-1:0] d);
      s_tvalid = 1'b1;
      s_tdata  = d;
      chk("wr_tready", 64'(s_tready), 64'(1));
      cycle();
      s_tvalid = 1'b0;
   endtask

   task automatic req(input logic [DW-1:0] d, input logic u);
      frame_req = 1'b1;
      push_exp(d, u);
      cycle();
      frame_req = 1'b0;
      chk("resp_latency", 64'(m_tvalid), 64'(1));
   endtask

   task automatic wr_req(input logic [DW-1:0] wd, input logic [DW-1:0] d, input logic u);
      s_tvalid  = 1'b1;
      s_tdata   = wd;
      frame_req = 1'b1;
      push_exp(d, u);
      chk("wr_req_tready", 64'(s_tready), 64'(1));
      cycle();
      s_tvalid  = 1'b0;
      frame_req = 1'b0;
      chk("resp_latency", 64'(m_tvalid), 64'(1));
   endtask

   // Scoreboard: every response pops the oldest expectation
   always @(negedge cmn_clk) begin
      if (cmn_rst_n) begin
         if (m_tvalid) begin
            checks++;
            assert (exp_q.size() > 0) else begin
               errors++;
               $error("FAIL resp_unexpected observed=response expected=no_response");
            end
            if (exp_q.size() > 0) begin
               exp_t e;
               e = exp_q.pop_front();
               chk("resp_data", 64'(m_tdata), 64'(e.d));
               chk("resp_underrun", 64'(underrun), 64'(e.u));
            end
         end else begin
            chk("underrun_without_valid", 64'(underrun), 64'(0));
         end
      end
   end

   initial begin
      cmn_rst_n = 1'b0;
      enable    = 1'b0;
      s_tvalid  = 1'b0;
      s_tdata   = '0;
      frame_req = 1'b0;
      repeat (3) @(negedge cmn_clk);
      cmn_rst_n = 1'b1;
      cycle();

      chk("rst_tready",   64'(s_tready),     64'(0));
      chk("rst_mvalid",   64'(m_tvalid),     64'(0));
      chk("rst_mdata",    64'(m_tdata),      64'(0));
      chk("rst_underrun", 64'(underrun),     64'(0));
      chk("rst_ucnt",     64'(underrun_cnt), 64'(0));
      chk("rst_fill_sel", 64'(fill_sel),     64'(0));
      chk("rst_playing",  64'(playing),      64'(0));

      // IDLE answers with silence and no underrun
      req('0, 1'b0);

      enable = 1'b1;
      cycle();
      chk("prime_tready",  64'(s_tready), 64'(1));
      chk("prime_playing", 64'(playing),  64'(0));
      req('0, 1'b0);

      // Prime and play
      for (int i = 1; i <= 3; i++) wr(DW'(i));
      chk("prime_fill_sel", 64'(fill_sel), 64'(0));
      wr(DW'(4));
      chk("swap_fill_sel", 64'(fill_sel), 64'(1));
      chk("swap_playing",  64'(playing),  64'(1));
      chk("swap_tready",   64'(s_tready), 64'(1));
      for (int i = 1; i <= 4; i++) req(DW'(i), 1'b0);
      chk("starve_playing", 64'(playing), 64'(0));

      // Starvation
      wr(DW'(5));
      wr(DW'(6));
      for (int i = 0; i < 3; i++) req('0, 1'b1);
      chk("starve_ucnt",    64'(underrun_cnt), 64'(3));
      chk("starve_playing2", 64'(playing),     64'(0));
      wr(DW'(7));
      wr(DW'(8));
      chk("recover_playing",  64'(playing),  64'(1));
      chk("recover_fill_sel", 64'(fill_sel), 64'(0));

      // Last read and completing write in the same cycle
      wr(DW'(9));
      wr(DW'(10));
      wr(DW'(11));
      req(DW'(5), 1'b0);
      req(DW'(6), 1'b0);
      req(DW'(7), 1'b0);
      wr_req(DW'(12), DW'(8), 1'b0);
      chk("simul_fill_sel", 64'(fill_sel), 64'(1));
      chk("simul_playing",  64'(playing),  64'(1));
      req(DW'(9), 1'b0);

      // Backpressure with the fill bank full
      for (int i = 13; i <= 16; i++) wr(DW'(i));
      s_tvalid = 1'b1;
      s_tdata  = DW'(99);
      chk("bp_tready0", 64'(s_tready), 64'(0));
      cycle();
      chk("bp_tready1", 64'(s_tready), 64'(0));
      req(DW'(10), 1'b0);
      req(DW'(11), 1'b0);
      chk("bp_tready2", 64'(s_tready), 64'(0));
      req(DW'(12), 1'b0);
      chk("bp_swap_fill_sel", 64'(fill_sel), 64'(0));
      chk("bp_swap_tready",   64'(s_tready), 64'(1));
      cycle();
      s_tvalid = 1'b0;
      req(DW'(13), 1'b0);

      // Disable mid-RUN: the same-cycle request still plays from RUN
      enable    = 1'b0;
      frame_req = 1'b1;
      push_exp(DW'(14), 1'b0);
      cycle();
      frame_req = 1'b0;
      chk("dis_latency",  64'(m_tvalid),     64'(1));
      chk("dis_playing",  64'(playing),      64'(0));
      chk("dis_tready",   64'(s_tready),     64'(0));
      chk("dis_fill_sel", 64'(fill_sel),     64'(0));
      chk("dis_ucnt",     64'(underrun_cnt), 64'(3));
      req('0, 1'b0);
      chk("dis_ucnt2",    64'(underrun_cnt), 64'(3));

      // Reset during an in-flight response
      frame_req = 1'b1;
      cycle();
      frame_req = 1'b0;
      chk("pre_rst_valid", 64'(m_tvalid), 64'(1));
      cmn_rst_n = 1'b0;
      #1;
      chk("async_rst_mvalid", 64'(m_tvalid),     64'(0));
      chk("async_rst_ucnt",   64'(underrun_cnt), 64'(0));
      chk("async_rst_mdata",  64'(m_tdata),      64'(0));
      @(negedge cmn_clk);
      cmn_rst_n = 1'b1;
      cycle();

      // Saturation of the underrun counter
      enable = 1'b1;
      cycle();
      for (int i = 21; i <= 24; i++) wr(DW'(i));
      for (int i = 21; i <= 24; i++) req(DW'(i), 1'b0);
      chk("sat_starve", 64'(playing), 64'(0));
      frame_req = 1'b1;
      for (int i = 0; i < 65540; i++) begin
         push_exp('0, 1'b1);
         cycle();
         if (i == 65533) chk("sat_ucnt_pre", 64'(underrun_cnt), 64'(16'hFFFE));
         if (i == 65534) chk("sat_ucnt_max", 64'(underrun_cnt), 64'(16'hFFFF));
      end
      frame_req = 1'b0;
      cycle();
      chk("sat_ucnt_hold", 64'(underrun_cnt), 64'(16'hFFFF));

      repeat (2) cycle();
      checks++;
      assert (exp_q.size() == 0) else begin
         errors++;
         $error("FAIL resp_missing observed=%0d pending expected=0", exp_q.size());
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
